// File: rtl/peripheral_gpio_apb_slave.sv
// APB slave register block for an 8-bit GPIO core: pad drive, input sync, level/edge interrupts.
// Latency: 2-cycle APB transfer (setup + access); input to IRQ_STAT in SYNC_DEPTH+1 cycles, to irq_o in SYNC_DEPTH+2.
// Backpressure: none; PREADY is tied high and every transfer completes with zero wait states.
module peripheral_gpio_apb_slave #(
  parameter int PADDR_SIZE = 10,
  parameter int PDATA_SIZE = 8,
  parameter int SYNC_DEPTH = 3
) (
  input  logic                  PCLK,
  input  logic                  PRESET,
  input  logic                  PSEL,
  input  logic                  PENABLE,
  input  logic [2:0]            PPROT,
  input  logic                  PWRITE,
  input  logic                  PSTRB,
  input  logic [PADDR_SIZE-1:0] PADDR,
  input  logic [PDATA_SIZE-1:0] PWDATA,
  output logic [PDATA_SIZE-1:0] PRDATA,
  output logic                  PREADY,
  output logic                  PSLVERR,
  input  logic [PDATA_SIZE-1:0] gpio_i,
  output logic [PDATA_SIZE-1:0] gpio_o,
  output logic [PDATA_SIZE-1:0] gpio_oe,
  output logic                  irq_o
);

  // A single flop cannot resolve metastability, so the chain is never shorter than two
  localparam int SD = (SYNC_DEPTH < 2) ? 2 : SYNC_DEPTH;

  localparam logic [PADDR_SIZE-1:0] A_MODE = PADDR_SIZE'(0);
  localparam logic [PADDR_SIZE-1:0] A_DIR  = PADDR_SIZE'(1);
  localparam logic [PADDR_SIZE-1:0] A_OUT  = PADDR_SIZE'(2);
  localparam logic [PADDR_SIZE-1:0] A_IN   = PADDR_SIZE'(3);
  localparam logic [PADDR_SIZE-1:0] A_TRIG = PADDR_SIZE'(4);
  localparam logic [PADDR_SIZE-1:0] A_POL  = PADDR_SIZE'(5);
  localparam logic [PADDR_SIZE-1:0] A_ENA  = PADDR_SIZE'(6);
  localparam logic [PADDR_SIZE-1:0] A_STAT = PADDR_SIZE'(7);
  localparam logic [PADDR_SIZE-1:0] A_END  = PADDR_SIZE'(8);

  logic [PDATA_SIZE-1:0] mode_r, dir_r, out_r, trig_r, pol_r, ena_r, stat_r;
  logic [PDATA_SIZE-1:0] sync_r [SD];
  logic [PDATA_SIZE-1:0] in_s, prev_r, evt, clr, rd_mux;
  logic                  setup_ph, access_ph, wr_en, addr_bad;

  // Protection attributes carry no meaning for this block
  logic unused_prot;
  assign unused_prot = ^PPROT;

  assign setup_ph  = PSEL & ~PENABLE;
  assign access_ph = PSEL & PENABLE;
  assign wr_en     = access_ph & PWRITE & PSTRB;
  assign addr_bad  = (PADDR >= A_END);
  assign in_s      = sync_r[SD-1];
  assign PREADY    = 1'b1;

  // Read mux over the current register state; unmapped addresses read as zero
  always_comb begin
    rd_mux = '0;
    case (PADDR)
      A_MODE:  rd_mux = mode_r;
      A_DIR:   rd_mux = dir_r;
      A_OUT:   rd_mux = out_r;
      A_IN:    rd_mux = in_s;
      A_TRIG:  rd_mux = trig_r;
      A_POL:   rd_mux = pol_r;
      A_ENA:   rd_mux = ena_r;
      A_STAT:  rd_mux = stat_r;
      default: rd_mux = '0;
    endcase
  end

  // Per-bit event: level match in level mode, selected edge in edge mode; plus W1C clear mask
  always_comb begin
    evt = (~trig_r & ~(in_s ^ pol_r))
        | (trig_r & ((pol_r & in_s & ~prev_r) | (~pol_r & ~in_s & prev_r)));
    clr = '0;
    if (wr_en && (PADDR == A_STAT)) clr = PWDATA;
  end

  // Pad input synchroniser and one-cycle history for edge detection
  always_ff @(posedge PCLK) begin
    if (PRESET) begin
      for (int i = 0; i < SD; i++) sync_r[i] <= '0;
      prev_r <= '0;
    end else begin
      sync_r[0] <= gpio_i;
      for (int i = 1; i < SD; i++) sync_r[i] <= sync_r[i-1];
      prev_r <= in_s;
    end
  end

  // Configuration registers commit on the access-phase edge of a strobed write
  always_ff @(posedge PCLK) begin
    if (PRESET) begin
      mode_r <= '0;
      dir_r  <= '0;
      out_r  <= '0;
      trig_r <= '0;
      pol_r  <= '0;
      ena_r  <= '0;
    end else if (wr_en) begin
      case (PADDR)
        A_MODE:  mode_r <= PWDATA;
        A_DIR:   dir_r  <= PWDATA;
        A_OUT:   out_r  <= PWDATA;
        A_TRIG:  trig_r <= PWDATA;
        A_POL:   pol_r  <= PWDATA;
        A_ENA:   ena_r  <= PWDATA;
        default: ;
      endcase
    end
  end

  // Status: events set regardless of enable; a same-cycle set beats the W1C clear
  always_ff @(posedge PCLK) begin
    if (PRESET) stat_r <= '0;
    else        stat_r <= (stat_r & ~clr) | evt;
  end

  // Interrupt line registered from enabled status
  always_ff @(posedge PCLK) begin
    if (PRESET) irq_o <= 1'b0;
    else        irq_o <= |(stat_r & ena_r);
  end

  // Response captured at the setup edge and held through the access cycle only
  always_ff @(posedge PCLK) begin
    if (PRESET) begin
      PRDATA  <= '0;
      PSLVERR <= 1'b0;
    end else if (setup_ph) begin
      PRDATA  <= rd_mux;
      PSLVERR <= addr_bad | ((PADDR == A_IN) & PWRITE & PSTRB);
    end else begin
      PRDATA  <= '0;
      PSLVERR <= 1'b0;
    end
  end

  // Open-drain bits only ever pull low: drive 0 and enable the pad when OUT is 0
  assign gpio_o  = out_r & ~mode_r;
  assign gpio_oe = dir_r & ~(mode_r & out_r);

endmodule
